ssd_scan_controller: RTL and testbench

- Time-multiplexing controller for a 4-digit common-anode seven-segment display.
- Holds a 4-digit BCD value and steps through the digits in turn.
- Uses one internal ssd_decoder instance to drive the shared active-low cathode bus (CA..CG, DP), together with a one-hot active-low anode select.
- Inserts a blanking gap between digits to prevent ghosting, applies new values only at frame boundaries, and supports leading-zero blanking and per-digit decimal points.

---
 rtl/ssd_scan_controller.sv | 179 +++++++++++++++++
 tb/tb_ssd_scan_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with inter-digit blanking,
// frame-synchronous value updates, leading-zero blanking and per-digit decimal points.

module ssd_decoder (
  input  logic [3:0] digit,
  output logic [7:0] seg
);
  // Active-low, seg[7:1] = CA..CG, seg[0] = DP (kept dark here)
  always_comb begin
    unique case (digit)
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      4'd9:    seg = 8'h09;
      default: seg = 8'hFF;
    endcase
  end
endmodule

module ssd_scan_controller #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_value_q, shadow_value_d, active_value_q, active_value_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic          shadow_lz_q, shadow_lz_d, active_lz_q, active_lz_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic          copy_active;
  logic [3:0]    digit_nib;
  logic [7:0]    dec_seg;
  logic [3:0]    is_zero, lz_mask;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    copy_active    = 1'b0;
    shadow_value_d = load ? value    : shadow_value_q;
    shadow_dp_d    = load ? dp_mask  : shadow_dp_q;
    shadow_lz_d    = load ? lz_blank : shadow_lz_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = 2'd0;
          cnt_d       = '0;
          copy_active = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == REFRESH_LAST) begin
            state_d     = BLANK;
            cnt_d       = '0;
            idx_d       = idx_q + 2'd1;
            copy_active = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
    // A load on the frame-start edge bypasses the shadow so it is not lost
    active_value_d = active_value_q;
    active_dp_d    = active_dp_q;
    active_lz_d    = active_lz_q;
    if (copy_active) begin
      active_value_d = load ? value    : shadow_value_q;
      active_dp_d    = load ? dp_mask  : shadow_dp_q;
      active_lz_d    = load ? lz_blank : shadow_lz_q;
    end
  end

  assign digit_nib = active_value_q[{idx_d, 2'b00} +: 4];

  ssd_decoder u_decoder (
    .digit (digit_nib),
    .seg   (dec_seg)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) is_zero[i] = (active_value_q[4*i +: 4] == 4'd0);
  end

  assign lz_mask = {active_lz_q & is_zero[3],
                    active_lz_q & is_zero[3] & is_zero[2],
                    active_lz_q & is_zero[3] & is_zero[2] & is_zero[1],
                    1'b0};

  // Outputs are computed from the next state so they line up with it when registered
  always_comb begin
    an_d         = 4'hF;
    seg_d        = 8'hFF;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      an_d         = ~(4'b0001 << idx_d);
      seg_d        = {lz_mask[idx_d] ? 7'h7F : dec_seg[7:1], ~active_dp_q[idx_d]};
      frame_done_d = (idx_d == 2'd3) && (cnt_d == REFRESH_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      shadow_value_q <= 16'h0;
      shadow_dp_q    <= 4'h0;
      shadow_lz_q    <= 1'b0;
      active_value_q <= 16'h0;
      active_dp_q    <= 4'h0;
      active_lz_q    <= 1'b0;
      an_q           <= 4'hF;
      seg_q          <= 8'hFF;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_lz_q    <= shadow_lz_d;
      active_value_q <= active_value_d;
      active_dp_q    <= active_dp_d;
      active_lz_q    <= active_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with REFRESH_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).

module tb_ssd_scan_controller;
   localparam int REFRESH = 4;
   localparam int BLANKC  = 2;
   localparam int PERIOD  = REFRESH + BLANKC;
   localparam int FRAME   = 4 * PERIOD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dpMask = 4'h0;
   logic        lzBlank = 1'b0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frameDone;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        lz;
      logic [31:0] segs;
   } vec_t;

   vec_t vectors [7];

   ssd_scan_controller #(.REFRESH_CYCLES(REFRESH), .BLANK_CYCLES(BLANKC)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_mask    (dpMask),
      .lz_blank   (lzBlank),
      .an         (an),
      .seg        (seg),
      .frame_done (frameDone)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Advance one edge and settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: bumps the counters and reports any difference
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Loads a value while idle, then enables so the next sample is frame cycle 0
   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp, input logic lz);
      enable  = 1'b0;
      load    = 1'b1;
      value   = v;
      dpMask  = dp;
      lzBlank = lz;
      tick();
      load   = 1'b0;
      enable = 1'b1;
      tick();
   endtask

   // Checks one whole frame; optional loads are injected on the edge after cycle la1/la2
   task automatic checkFrame(input string tag, input logic [31:0] segs,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
      for (int c = 0; c < FRAME; c++) begin
         int d;
         int p;
         logic [3:0] expAn;
         logic [7:0] expSeg;
         logic       expFd;
         d = c / PERIOD;
         p = c % PERIOD;
         if (p < BLANKC) begin
            expAn  = 4'hF;
            expSeg = 8'hFF;
            expFd  = 1'b0;
         end else begin
            expAn  = ~(4'b0001 << d);
            expSeg = segs[8*d +: 8];
            expFd  = (d == 3) && (p == PERIOD - 1);
         end
         checkOutput($sformatf("%s c%0d an", tag, c), {4'h0, an}, {4'h0, expAn});
         checkOutput($sformatf("%s c%0d seg", tag, c), seg, expSeg);
         checkOutput($sformatf("%s c%0d frame_done", tag, c), {7'h0, frameDone}, {7'h0, expFd});
         if (c == la1) begin
            load  = 1'b1;
            value = lv1;
         end else if (c == la2) begin
            load  = 1'b1;
            value = lv2;
         end
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      // segs packed as {digit3, digit2, digit1, digit0}
      vectors[0] = '{16'h1234, 4'b0000, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
      vectors[1] = '{16'h0007, 4'b0100, 1'b1, {8'hFF, 8'hFE, 8'hFF, 8'h1F}};
      vectors[2] = '{16'h0007, 4'b0000, 1'b0, {8'h03, 8'h03, 8'h03, 8'h1F}};
      vectors[3] = '{16'hABCD, 4'b1111, 1'b1, {8'hFE, 8'hFE, 8'hFE, 8'hFE}};
      vectors[4] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
      vectors[5] = '{16'h0100, 4'b0001, 1'b1, {8'hFF, 8'h9F, 8'h03, 8'h02}};
      vectors[6] = '{16'h8888, 4'b0000, 1'b0, {8'h01, 8'h01, 8'h01, 8'h01}};

      tick();
      tick();
      checkOutput("reset an", {4'h0, an}, 8'h0F);
      checkOutput("reset seg", seg, 8'hFF);
      checkOutput("reset frame_done", {7'h0, frameDone}, 8'h00);
      reset = 1'b0;
      tick();
      checkOutput("idle an", {4'h0, an}, 8'h0F);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i].value, vectors[i].dp, vectors[i].lz);
         checkFrame($sformatf("vec%0d", i), vectors[i].segs, -1, 16'h0, -1, 16'h0);
      end

      // Two loads inside one frame: the running frame is untouched and only the last load shows
      applyStimulus(16'h1234, 4'b0000, 1'b0);
      checkFrame("midload", {8'h9F, 8'h25, 8'h0D, 8'h99}, 5, 16'h5555, 15, 16'h9999);
      // Load exactly on the wrap edge takes effect in the frame that starts there
      checkFrame("last9999", {8'h09, 8'h09, 8'h09, 8'h09}, FRAME - 1, 16'h8888, -1, 16'h0);
      checkFrame("wrap8888", {8'h01, 8'h01, 8'h01, 8'h01}, -1, 16'h0, -1, 16'h0);

      // Disable during digit 2 SHOW, then re-enable from digit 0
      for (int c = 0; c < 2 * PERIOD + BLANKC; c++) tick();
      checkOutput("pre-disable an", {4'h0, an}, 8'h0B);
      enable = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checkOutput($sformatf("disabled%0d an", k), {4'h0, an}, 8'h0F);
         checkOutput($sformatf("disabled%0d seg", k), seg, 8'hFF);
         checkOutput($sformatf("disabled%0d frame_done", k), {7'h0, frameDone}, 8'h00);
      end
      enable = 1'b1;
      tick();
      checkFrame("reenable", {8'h01, 8'h01, 8'h01, 8'h01}, -1, 16'h0, -1, 16'h0);

      // Reset mid-SHOW clears outputs and all stored values
      for (int c = 0; c < BLANKC + 1; c++) tick();
      checkOutput("pre-reset an", {4'h0, an}, 8'h0E);
      reset = 1'b1;
      tick();
      checkOutput("midreset an", {4'h0, an}, 8'h0F);
      checkOutput("midreset seg", seg, 8'hFF);
      checkOutput("midreset frame_done", {7'h0, frameDone}, 8'h00);
      reset = 1'b0;
      tick();
      checkFrame("postreset", {8'h03, 8'h03, 8'h03, 8'h03}, -1, 16'h0, -1, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
